disc_sample_arbiter: RTL
========================

// Module: disc_sample_arbiter
// PURPOSE
// - Sequences and shares one multi-distribution discrete sampler among N_REQ requesters.
// - Drives the sampler's synchronous reset and waits for its pipeline to fill.
// - Grants at most one request per cycle, round-robin, and returns the sampled m to the winner, tagged with its id.
// - Sits between the search engines that consume random symbols and the sampler instance.
// PARAMETERS
// - N_REQ        4   number of requesters (>=2)
// - K            4   number of distributions in the sampler (>=2); SEL_W = $clog2(K)
// - M            16  sampler alphabet max; MW = $clog2(M+1)
// - INIT_CYCLES  4   cycles smp_reset is held high after reset_n release or restart (>=1)
// - CNT_W        32  width of served-sample counter
// PORTS
// - clk          in   1            clock, all logic rising-edge
// - reset_n      in   1            asynchronous active-low reset
// - restart      in   1            pulse: re-reset the sampler and re-sequence (reseed)
// - req          in   N_REQ        per-requester request level; held until granted
// - req_sel      in   N_REQ*SEL_W  distribution index for requester r at [r*SEL_W +: SEL_W]
// - gnt          out  N_REQ        one-hot grant pulse; requester may drop/change req next cycle
// - rsp_valid    out  1            response pulse, one cycle after gnt
// - rsp_id       out  $clog2(N_REQ)  id of granted requester
// - rsp_m        out  MW           sampled value in 1..M
// - rsp_err      out  1            granted req_sel >= K (rsp_m forced 0)
// - ready        out  1            high in SERVE state
// - served_cnt   out  CNT_W        count of rsp_valid pulses since reset_n; wraps
// - smp_reset    out  1            to sampler reset (synchronous active-high there)
// - smp_sel      out  SEL_W        to sampler sel (its output mux is combinational)
// - smp_m        in   MW           from sampler m
// - smp_valid    in   1            from sampler valid
// BEHAVIOUR
// - Reset (reset_n low, async): state=HOLD, hold_cnt=0, smp_reset=1, rr_ptr=0, gnt=0,
//   rsp_valid=0, rsp_id=0, rsp_m=0, rsp_err=0, ready=0, served_cnt=0, smp_sel=0.
// - FSM HOLD: smp_reset=1; hold_cnt increments; when hold_cnt==INIT_CYCLES-1 -> FILL, clear hold_cnt.
// - FSM FILL: smp_reset=0; wait; smp_valid==1 -> SERVE; no grants in FILL.
// - FSM SERVE: ready=1; smp_valid==0 (unexpected) -> FILL with no grant that cycle.
// - restart high in any state -> HOLD next cycle, hold_cnt=0; no grant in the restart cycle.
// - Arbitration (SERVE & smp_valid & !restart): winner = first r with req[r] at or after rr_ptr, wrapping modulo N_REQ.
//   - Combinational: gnt[winner]=1, smp_sel=req_sel[winner].
//   - Registered: rr_ptr = (winner+1) mod N_REQ.
//   - Otherwise gnt=0 and smp_sel=0.
// - gnt is combinational from req/state; requester samples it on the same edge.
// - Latency: the edge after gnt presents rsp_valid=1, rsp_id=winner, and rsp_m=smp_m (captured at the grant edge).
//   - If req_sel>=K: rsp_err=1 and rsp_m=0.
//   - Otherwise rsp_err=0.
// - rsp_id/rsp_m/rsp_err hold their last values when rsp_valid=0.
// - Throughput: one grant per cycle; a single requester that keeps req high is granted every cycle.
// - Fairness: with all N_REQ requesting, grants cycle 0,1,..,N_REQ-1; no requester waits >N_REQ-1 grants.
// - served_cnt increments on each rsp_valid and wraps 2^CNT_W-1 -> 0; restart does not clear it.
// - A response already in flight when restart is asserted is still delivered (it was sampled before the reset).
// - Mid-operation reset_n: all state cleared immediately; pending reqs are served after the next HOLD/FILL.
// STRUCTURE
// - Shared package dts_pkg: arb state enum {HOLD,FILL,SERVE}; SEL_W/MW width functions.
// - One sub-module: rr_arbiter (N_REQ req + ptr -> one-hot gnt and encoded winner), reusable elsewhere.
// - Sampler is not instantiated inside; top level wires smp_* to it (shared K, M).
// TESTING
// - Release reset_n -> smp_reset high exactly INIT_CYCLES=4 cycles, then ready rises the cycle after smp_valid=1.
// - req=4'b1111, all sel=1 -> gnt 0001,0010,0100,1000,0001...; rsp_id 0,1,2,3 one cycle later.
// - req=4'b0100, sel2=3, sampler model with m=7 -> gnt every cycle, rsp_m=7, rsp_err=0, served_cnt +1 per cycle.
// - K=3, req_sel=3 -> granted, rsp_err=1, rsp_m=0.
// - restart pulse mid-stream -> in-flight rsp delivered; gnt=0 through HOLD(4)+FILL; resumes from saved rr_ptr.
// - reset_n low mid-stream -> outputs zero asynchronously; served_cnt=0; sequence restarts from HOLD.

Source files
------------

// File: rtl/dts_pkg.sv
// Shared types and width helpers for the discrete-sampler arbiter and its neighbours.
// Combinational helpers only; no latency and no backpressure.
package dts_pkg;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      FILL  = 2'd1,
      SERVE = 2'd2
   } arb_state_t;

   function automatic int sel_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

   function automatic int m_width(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping; one-hot grant plus encoded winner.
// Purely combinational (0 cycles); the caller masks req to apply backpressure.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] winner,
   output logic          any
);

   int idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = IW'(idx);
         end
      end
      if (any) gnt[winner] = 1'b1;
   end

endmodule

// File: rtl/disc_sample_arbiter.sv
// Sequences the shared discrete sampler (reset hold, pipeline fill) and shares it round-robin.
// Grant is same-cycle combinational, response one cycle later; requesters hold req until granted.
module disc_sample_arbiter
   import dts_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int K           = 4,
   parameter int M           = 16,
   parameter int INIT_CYCLES = 4,
   parameter int CNT_W       = 32,
   localparam int SEL_W      = sel_width(K),
   localparam int MW         = m_width(M),
   localparam int ID_W       = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   restart,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*SEL_W-1:0] req_sel,
   output logic [N_REQ-1:0]       gnt,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [MW-1:0]          rsp_m,
   output logic                   rsp_err,
   output logic                   ready,
   output logic [CNT_W-1:0]       served_cnt,
   output logic                   smp_reset,
   output logic [SEL_W-1:0]       smp_sel,
   input  logic [MW-1:0]          smp_m,
   input  logic                   smp_valid
);

   localparam int HC_W = $clog2(INIT_CYCLES) + 1;

   arb_state_t       state, state_nxt;
   logic [HC_W-1:0]  hold_cnt, hold_cnt_nxt;
   logic [ID_W-1:0]  rr_ptr, winner;
   logic [SEL_W-1:0] win_sel;
   logic             grant_ok, any_gnt, sel_err;

   assign grant_ok  = (state == SERVE) && smp_valid && !restart;
   assign smp_reset = (state == HOLD);
   assign ready     = (state == SERVE);

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req    (req & {N_REQ{grant_ok}}),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .winner (winner),
      .any    (any_gnt)
   );

   assign win_sel = req_sel[int'(winner)*SEL_W +: SEL_W];
   assign sel_err = (int'(win_sel) >= K);
   assign smp_sel = any_gnt ? win_sel : '0;

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      if (restart) begin
         state_nxt    = HOLD;
         hold_cnt_nxt = '0;
      end else begin
         case (state)
            HOLD: begin
               if (hold_cnt == HC_W'(INIT_CYCLES - 1)) begin
                  state_nxt    = FILL;
                  hold_cnt_nxt = '0;
               end else begin
                  hold_cnt_nxt = hold_cnt + HC_W'(1);
               end
            end
            FILL:    if (smp_valid) state_nxt = SERVE;
            // Sampler dropped valid: stop granting until the pipeline refills.
            SERVE:   if (!smp_valid) state_nxt = FILL;
            default: begin
               state_nxt    = HOLD;
               hold_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= HOLD;
         hold_cnt   <= '0;
         rr_ptr     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_m      <= '0;
         rsp_err    <= 1'b0;
         served_cnt <= '0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_cnt_nxt;
         rsp_valid <= any_gnt;
         if (any_gnt) begin
            rr_ptr     <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
            rsp_id     <= winner;
            rsp_err    <= sel_err;
            rsp_m      <= sel_err ? '0 : smp_m;
            served_cnt <= served_cnt + CNT_W'(1);
         end
      end
   end

endmodule
